mul_float_seq: RTL and testbench

Parametrised, sequential IEEE-754-style floating-point multiplier. It is the next generation of the single-precision multiplier and is generic in exponent and mantissa width. It adds a valid/ready handshake, an iterative shift-add mantissa datapath, round-to-nearest-even with guard/round/sticky, and full special-case handling. It sits between the register-file read stage and the FP writeback arbiter, and one instance serves each FP lane.

---
 rtl/fp_pkg.sv | 43 ++++
 rtl/mul_int_seq.sv | 54 +++++
 rtl/mul_float_seq.sv | 189 ++++++++++++++++++
 tb/tb_mul_float_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point helpers: bias, special-value builders, FSM states, flags.
package fp_pkg;

  // Widest format the builders below can produce.
  localparam int FP_MAX_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_DONE
  } mulf_state_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic invalid;
    logic inexact;
  } mulf_flags_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Quiet NaN: exponent all ones, top mantissa bit set, sign clear.
  function automatic logic [FP_MAX_W-1:0] fp_nan(input int exp_w, input int man_w);
    return (((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1)) << man_w) |
           (FP_MAX_W'(1) << (man_w - 1));
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_inf(input int exp_w, input int man_w,
                                                 input logic sign);
    return (((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1)) << man_w) |
           (FP_MAX_W'(sign) << (exp_w + man_w));
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_zero(input int exp_w, input int man_w,
                                                  input logic sign);
    return FP_MAX_W'(sign) << (exp_w + man_w);
  endfunction

endpackage

// File: rtl/mul_int_seq.sv
// Iterative radix-2 shift-add unsigned multiplier, one multiplier bit per cycle.
// The first partial product is folded into the start edge, so the remaining
// N-1 steps run while the caller waits for done_o.
module mul_int_seq #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           done_o,
  output logic [2*N-1:0] p_o
);

  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] acc_q, acc_d, acc_src;
  logic [N-1:0]   mcand_q, mcand_src;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic [N:0]     sum;

  // Multiplier lives in the low half of the accumulator and shifts out as the
  // product shifts in from the top.
  assign acc_src   = start_i ? {{N{1'b0}}, b_i} : acc_q;
  assign mcand_src = start_i ? a_i : mcand_q;
  assign sum       = {1'b0, acc_src[2*N-1:N]} + {1'b0, mcand_src & {N{acc_src[0]}}};
  assign acc_d     = {sum, acc_src[N-1:1]};

  // done_o marks the cycle whose closing edge performs the final step.
  assign done_o = busy_q && (cnt_q == CW'(N - 1));
  assign p_o    = acc_q;

  // Step counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start_i) begin
      acc_q   <= acc_d;
      mcand_q <= a_i;
      cnt_q   <= CW'(1);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_float_seq.sv
// Sequential floating-point multiplier: special-case decode, iterative
// significand product, normalise, round-to-nearest-even, flags.
module mul_float_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c,
  output logic         overflow,
  output logic         underflow,
  output logic         invalid,
  output logic         inexact
);

  localparam int N   = MAN_W + 1;
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] BIAS_S  = EW2'(fp_bias(EXP_W));
  localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);
  localparam logic [W-1:0]          QNAN    = W'(fp_nan(EXP_W, MAN_W));

  mulf_state_t state_q, state_d;
  logic                  sign_q, sign_d;
  logic signed [EW2-1:0] exp_q, exp_d;
  logic [N-1:0]          man_q, man_d;
  logic                  g_q, g_d, r_q, r_d, s_q, s_d;
  logic [W-1:0]          c_q, c_d;
  mulf_flags_t           flg_q, flg_d;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic mul_start, mul_done;
  logic [2*N-1:0] prod;

  logic nrm_hi, nrm_g, nrm_r, nrm_s;
  logic [N-1:0] nrm_man;
  logic rnd_inc;
  logic [N:0] man_sum;
  logic [MAN_W-1:0] rnd_frac;
  logic signed [EW2-1:0] rnd_exp;

  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign ma = a[MAN_W-1:0];
  assign mb = b[MAN_W-1:0];

  // Denormals have a zero exponent and are flushed to zero here.
  assign a_nan  = (&ea) & (|ma);
  assign b_nan  = (&eb) & (|mb);
  assign a_inf  = (&ea) & ~(|ma);
  assign b_inf  = (&eb) & ~(|mb);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);

  mul_int_seq #(.N(N)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(mul_start),
    .a_i    ({1'b1, ma}),
    .b_i    ({1'b1, mb}),
    .done_o (mul_done),
    .p_o    (prod)
  );

  // Product lies in [1,4): the top bit picks between the two alignments.
  assign nrm_hi  = prod[2*N-1];
  assign nrm_man = nrm_hi ? prod[2*N-1:N] : prod[2*N-2:N-1];
  assign nrm_g   = nrm_hi ? prod[N-1] : prod[N-2];
  assign nrm_r   = nrm_hi ? prod[N-2] : prod[N-3];
  assign nrm_s   = nrm_hi ? (|prod[N-3:0]) : (|prod[N-4:0]);

  // RNE increment; a carry out of the significand renormalises by one.
  assign rnd_inc  = g_q & (r_q | s_q | man_q[0]);
  assign man_sum  = {1'b0, man_q} + {{N{1'b0}}, rnd_inc};
  assign rnd_frac = man_sum[N] ? man_sum[MAN_W:1] : man_sum[MAN_W-1:0];
  assign rnd_exp  = exp_q + {{(EW2-1){1'b0}}, man_sum[N]};

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign c         = c_q;
  assign overflow  = flg_q.overflow;
  assign underflow = flg_q.underflow;
  assign invalid   = flg_q.invalid;
  assign inexact   = flg_q.inexact;

  // Next-state and datapath update for every FSM state.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    man_d     = man_q;
    g_d       = g_q;
    r_d       = r_q;
    s_d       = s_q;
    c_d       = c_q;
    flg_d     = flg_q;
    mul_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = a[W-1] ^ b[W-1];
          exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
          flg_d  = '0;
          if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) begin
            c_d           = QNAN;
            flg_d.invalid = 1'b1;
            state_d       = S_DONE;
          end else if (a_inf | b_inf) begin
            c_d     = W'(fp_inf(EXP_W, MAN_W, a[W-1] ^ b[W-1]));
            state_d = S_DONE;
          end else if (a_zero | b_zero) begin
            c_d     = W'(fp_zero(EXP_W, MAN_W, a[W-1] ^ b[W-1]));
            state_d = S_DONE;
          end else begin
            mul_start = 1'b1;
            state_d   = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (mul_done) state_d = S_NORM;
      end
      S_NORM: begin
        man_d   = nrm_man;
        g_d     = nrm_g;
        r_d     = nrm_r;
        s_d     = nrm_s;
        exp_d   = exp_q + {{(EW2-1){1'b0}}, nrm_hi};
        state_d = S_ROUND;
      end
      S_ROUND: begin
        flg_d = '0;
        if (rnd_exp >= EXP_MAX) begin
          c_d             = W'(fp_inf(EXP_W, MAN_W, sign_q));
          flg_d.overflow  = 1'b1;
          flg_d.inexact   = 1'b1;
        end else if (rnd_exp[EW2-1] || (rnd_exp == '0)) begin
          c_d             = W'(fp_zero(EXP_W, MAN_W, sign_q));
          flg_d.underflow = 1'b1;
          flg_d.inexact   = 1'b1;
        end else begin
          c_d           = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
          flg_d.inexact = g_q | r_q | s_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      man_q   <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      c_q     <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      g_q     <= g_d;
      r_q     <= r_d;
      s_q     <= s_d;
      c_q     <= c_d;
      flg_q   <= flg_d;
    end
  end

endmodule

// File: tb/tb_mul_float_seq.sv
// Bench for mul_float_seq (single-precision defaults): directed and random
// operands checked against an arithmetic reference model.
module tb_mul_float_seq;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, c;
  logic        overflow, underflow, invalid, inexact;
  logic [3:0]  dflags;

  int tests = 0;
  int fails = 0;
  logic [35:0] expq[$];

  assign dflags = {overflow, underflow, invalid, inexact};

  mul_float_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c),
    .overflow(overflow), .underflow(underflow), .invalid(invalid), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: exact integer product, then RNE by comparing the discarded
  // remainder against one half ulp. Returns {c, ovf, unf, inv, inx}.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e, sh;
    longint unsigned mx, my, p, keep, rem, half;
    logic s, ovf, unf, inv, inx;
    logic xnan, ynan, xinf, yinf, xz, yz;
    logic [31:0] r;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    s = x[31] ^ y[31];
    xnan = (ex == 255) && (x[22:0] != 0); ynan = (ey == 255) && (y[22:0] != 0);
    xinf = (ex == 255) && (x[22:0] == 0); yinf = (ey == 255) && (y[22:0] == 0);
    xz = (ex == 0); yz = (ey == 0);
    ovf = 0; unf = 0; inv = 0; inx = 0;
    if (xnan || ynan || (xinf && yz) || (xz && yinf)) begin
      r = 32'h7FC00000; inv = 1;
    end else if (xinf || yinf) begin
      r = {s, 8'hFF, 23'd0};
    end else if (xz || yz) begin
      r = {s, 31'd0};
    end else begin
      mx = (64'd1 << 23) | 64'(x[22:0]);
      my = (64'd1 << 23) | 64'(y[22:0]);
      p = mx * my;
      e = ex + ey - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin sh = 24; e++; end
      keep = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep++;
      if (keep == (64'd1 << 24)) begin keep = keep >> 1; e++; end
      inx = (rem != 0);
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0}; ovf = 1; inx = 1;
      end else if (e <= 0) begin
        r = {s, 31'd0}; unf = 1; inx = 1;
      end else begin
        r = {s, e[7:0], keep[22:0]};
      end
    end
    return {r, ovf, unf, inv, inx};
  endfunction

  // Scoreboard: queue expectations at accept, check every DONE cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
    end else begin
      if (in_valid && in_ready) expq.push_back(model(a, b));
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_out_valid", 36'(out_valid), 36'(0));
        end else begin
          chk("result_c", 36'(c), 36'(expq[0][35:4]));
          chk("flags", 36'(dflags), 36'(expq[0][3:0]));
          if (out_ready) void'(expq.pop_front());
        end
        chk("in_ready_in_done", 36'(in_ready), 36'(0));
      end
    end
  end

  // One operation; starts and ends just after a rising edge.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                        input int exp_lat, input int stall);
    int n;
    a = xa; b = xb; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      chk("accept_timeout", 36'(in_ready), 36'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("latency", 36'(n), 36'(exp_lat));
    if (!out_valid) return;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid_busy", 36'({out_valid, in_ready}), 36'(2'b10));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handshake_to_idle", 36'({out_valid, in_ready}), 36'(2'b01));
  endtask

  initial begin
    int bad;
    clk = 0; rst_n = 0; in_valid = 0; out_ready = 0; a = '0; b = '0;
    #12;
    chk("reset_state", {c, out_valid, in_ready, dflags[3:2]}, {32'd0, 4'b0100});
    chk("reset_flags", 36'(dflags), 36'(0));

    // Hand-computed values that pin the reference model.
    chk("model_simple", model(32'h3FC00000, 32'h40000000), {32'h40400000, 4'b0000});
    chk("model_tie",    model(32'h3F800800, 32'h3F800800), {32'h3F801000, 4'b0001});
    chk("model_ovf",    model(32'h7F7FFFFF, 32'h40000000), {32'h7F800000, 4'b1001});
    chk("model_unf",    model(32'h80800000, 32'h00800000), {32'h80000000, 4'b0101});
    chk("model_infx0",  model(32'h7F800000, 32'h00000000), {32'h7FC00000, 4'b0010});
    chk("model_ninf",   model(32'hFF800000, 32'h40000000), {32'hFF800000, 4'b0000});
    chk("model_inexact", model(32'h3F800001, 32'h3F800001), {32'h3F800002, 4'b0001});

    @(posedge clk); #1;
    rst_n = 1;

    run_op(32'h3FC00000, 32'h40000000, 26, 0);
    run_op(32'h3F800800, 32'h3F800800, 26, 0);
    run_op(32'h7F7FFFFF, 32'h40000000, 26, 0);
    run_op(32'h80800000, 32'h00800000, 26, 0);
    run_op(32'h7F800000, 32'h00000000, 1, 0);
    run_op(32'hFF800000, 32'h40000000, 1, 0);
    run_op(32'hBFC00000, 32'h40000000, 26, 5);
    run_op(32'h40400000, 32'h40400000, 26, 0);
    run_op(32'h7F800000, 32'h3F800000, 1, 3);
    run_op(32'h7FC00001, 32'h3F800000, 1, 0);
    run_op(32'h00000001, 32'h3F800000, 1, 0);
    run_op(32'h00000000, 32'hFF800000, 1, 0);
    run_op(32'h3F800001, 32'h3F800001, 26, 0);
    run_op(32'h3FFFFFFF, 32'h3FFFFFFF, 26, 0);
    run_op(32'h3F7FFFFF, 32'h3F800001, 26, 0);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra, rb;
      ra = {1'($urandom_range(1)), 8'($urandom_range(154, 100)), 23'($urandom)};
      rb = {1'($urandom_range(1)), 8'($urandom_range(154, 100)), 23'($urandom)};
      run_op(ra, rb, 26, 0);
    end

    // Abort an operation partway through the significand product.
    a = 32'h40A00000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("reset_abort_now", 36'({out_valid, in_ready}), 36'(2'b01));
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) bad++; end
    chk("no_partial_result", 36'(bad), 36'(0));
    run_op(32'h3FC00000, 32'h40000000, 26, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule
